word_data_ctrl: RTL and testbench

- Data-word memory controller directly downstream of the word CPU's data stage.
- Serves the CPU's word load/store port (OE/WE/RDY handshake) and a host/IO process-image port from one internal single-port synchronous RAM.
- The CPU normally has priority. A starvation counter forces periodic host slots.
- Provides DW_I/DW_RDY to the CPU with the timing its stall logic requires.

---
 rtl/word_data_ctrl_pkg.sv | 18 +
 rtl/word_data_ctrl_ram.sv | 24 ++
 rtl/word_data_ctrl.sv | 127 ++++++++++++
 tb/tb_word_data_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/word_data_ctrl_pkg.sv
// rtl/word_data_ctrl_pkg.sv - shared FSM encodings and address range helper for word_data_ctrl
package word_data_ctrl_pkg;

  // Arbiter FSM: IDLE accepts a host grant, HOST_ACK presents the one-cycle acknowledge
  typedef enum logic {
    S_IDLE     = 1'b0,
    S_HOST_ACK = 1'b1
  } state_t;

  localparam int         CNT_W   = 8;
  localparam logic [7:0] CNT_SAT = 8'hFF;

  // True when a word address falls inside the implemented RAM
  function automatic logic addr_ok(input logic [31:0] addr, input logic [31:0] depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/word_data_ctrl_ram.sv
// rtl/word_data_ctrl_ram.sv - single-port synchronous word RAM with registered read data
module word_ram #(
  parameter int DEPTH = 1024,
  parameter int DW_W  = 32,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   addr,
  input  logic [DW_W-1:0] wd,
  output logic [DW_W-1:0] rd
);

  logic [DW_W-1:0] mem [DEPTH];

  // One port: write when enabled, always register the addressed word
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wd;
    end
    rd <= mem[addr];
  end

endmodule

// File: rtl/word_data_ctrl.sv
// rtl/word_data_ctrl.sv - CPU/host arbitrated data-word memory controller
module word_data_ctrl
  import word_data_ctrl_pkg::*;
#(
  parameter int DA_W       = 16,
  parameter int DW_W       = 32,
  parameter int DEPTH      = 1024,
  parameter int STARVE_MAX = 4
) (
  input  logic            CLK,
  input  logic            CLR,
  input  logic [DA_W-1:0] DW_A,
  input  logic [DW_W-1:0] DW_O,
  input  logic            DW_OE,
  input  logic            DW_WE,
  output logic [DW_W-1:0] DW_I,
  output logic            DW_RDY,
  input  logic [DA_W-1:0] H_A,
  input  logic [DW_W-1:0] H_WD,
  input  logic            H_REQ,
  input  logic            H_WE,
  output logic [DW_W-1:0] H_RD,
  output logic            H_ACK
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             host_gnt;
  logic             cpu_wr;
  logic             cpu_rd;
  logic             c_in;
  logic             h_in;
  logic             ram_we;
  logic [AW-1:0]    ram_addr;
  logic [DW_W-1:0]  ram_wd;
  logic [DW_W-1:0]  ram_rd;
  logic             dwi_pend;
  logic             dwi_oor;
  logic             hrd_pend;
  logic             hrd_oor;
  logic [DW_W-1:0]  dw_i_q;
  logic [DW_W-1:0]  h_rd_q;
  logic [DW_W-1:0]  hrd_data;

  // Host wins only in IDLE, and against a CPU request only once it has starved long enough
  assign host_gnt = H_REQ && (state == S_IDLE) &&
                    (!(DW_OE || DW_WE) || (int'(cnt) >= STARVE_MAX));
  assign DW_RDY   = !host_gnt;
  assign cpu_wr   = DW_WE && DW_RDY;
  assign cpu_rd   = DW_OE && !DW_WE && DW_RDY;
  assign c_in     = addr_ok(32'(DW_A), 32'(DEPTH));
  assign h_in     = addr_ok(32'(H_A), 32'(DEPTH));

  // RAM port steering; out-of-range writes are suppressed here
  assign ram_we   = host_gnt ? (H_WE && h_in) : (cpu_wr && c_in);
  assign ram_addr = host_gnt ? H_A[AW-1:0] : DW_A[AW-1:0];
  assign ram_wd   = host_gnt ? H_WD : DW_O;

  word_ram #(
    .DEPTH (DEPTH),
    .DW_W  (DW_W),
    .AW    (AW)
  ) u_ram (
    .clk  (CLK),
    .we   (ram_we),
    .addr (ram_addr),
    .wd   (ram_wd),
    .rd   (ram_rd)
  );

  // Host read data comes straight from the RAM register during the ACK cycle, then is held
  assign hrd_data = hrd_oor ? '0 : ram_rd;
  assign H_RD     = hrd_pend ? hrd_data : h_rd_q;
  assign DW_I     = dw_i_q;

  // Arbiter FSM with registered acknowledge
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state <= S_IDLE;
      H_ACK <= 1'b0;
    end else begin
      H_ACK <= host_gnt;
      case (state)
        S_IDLE:     state <= host_gnt ? S_HOST_ACK : S_IDLE;
        S_HOST_ACK: state <= S_IDLE;
        default:    state <= S_IDLE;
      endcase
    end
  end

  // Starvation counter: counts denied host cycles in IDLE, cleared by grant or request drop
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      cnt <= '0;
    end else if (!H_REQ || host_gnt) begin
      cnt <= '0;
    end else if ((state == S_IDLE) && (cnt != CNT_SAT)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Read-data pipeline: RAM output lands in DW_I / H_RD one edge after acceptance
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      dwi_pend <= 1'b0;
      dwi_oor  <= 1'b0;
      hrd_pend <= 1'b0;
      hrd_oor  <= 1'b0;
      dw_i_q   <= '0;
      h_rd_q   <= '0;
    end else begin
      dwi_pend <= cpu_rd;
      dwi_oor  <= !c_in;
      hrd_pend <= host_gnt && !H_WE;
      hrd_oor  <= !h_in;
      if (dwi_pend) begin
        dw_i_q <= dwi_oor ? '0 : ram_rd;
      end
      if (hrd_pend) begin
        h_rd_q <= hrd_data;
      end
    end
  end

endmodule

// File: tb/tb_word_data_ctrl.sv
// tb/tb_word_data_ctrl.sv - scoreboard testbench for word_data_ctrl
module tb_word_data_ctrl;

  localparam int DA_W       = 16;
  localparam int DW_W       = 32;
  localparam int DEPTH      = 1024;
  localparam int STARVE_MAX = 4;

  logic            CLK = 1'b0;
  logic            CLR;
  logic [DA_W-1:0] DW_A;
  logic [DW_W-1:0] DW_O;
  logic            DW_OE;
  logic            DW_WE;
  logic [DW_W-1:0] DW_I;
  logic            DW_RDY;
  logic [DA_W-1:0] H_A;
  logic [DW_W-1:0] H_WD;
  logic            H_REQ;
  logic            H_WE;
  logic [DW_W-1:0] H_RD;
  logic            H_ACK;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem_m [int];
  logic [31:0] q_dwi [$];
  logic [31:0] q_hrd [$];
  logic        pend_r;
  logic [31:0] last_dwi;
  logic [31:0] last_hrd;
  logic        acc;

  always #5 CLK = ~CLK;

  word_data_ctrl #(
    .DA_W       (DA_W),
    .DW_W       (DW_W),
    .DEPTH      (DEPTH),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .CLK    (CLK),
    .CLR    (CLR),
    .DW_A   (DW_A),
    .DW_O   (DW_O),
    .DW_OE  (DW_OE),
    .DW_WE  (DW_WE),
    .DW_I   (DW_I),
    .DW_RDY (DW_RDY),
    .H_A    (H_A),
    .H_WD   (H_WD),
    .H_REQ  (H_REQ),
    .H_WE   (H_WE),
    .H_RD   (H_RD),
    .H_ACK  (H_ACK)
  );

  function automatic logic [31:0] mread(input logic [15:0] a);
    if (int'(a) >= DEPTH) return 32'h0;
    if (!mem_m.exists(int'(a))) return 32'h0;
    return mem_m[int'(a)];
  endfunction

  task automatic mwrite(input logic [15:0] a, input logic [31:0] d);
    if (int'(a) < DEPTH) mem_m[int'(a)] = d;
  endtask

  task automatic idle_inputs();
    DW_A = '0; DW_O = '0; DW_OE = 1'b0; DW_WE = 1'b0;
    H_A = '0; H_WD = '0; H_REQ = 1'b0; H_WE = 1'b0;
  endtask

  task automatic clear_sb();
    q_dwi.delete();
    q_hrd.delete();
    pend_r   = 1'b0;
    last_dwi = '0;
    last_hrd = '0;
  endtask

  // One clock: check comb RDY before the edge, registered outputs after it
  task automatic tick(input logic exp_rdy, input logic exp_ack, output logic accepted);
    logic rd_acc, hg, hg_rd, cmp;
    #1;
    checks++;
    if (DW_RDY !== exp_rdy) begin
      failures++;
      $display("FAIL dw_rdy t=%0t got=%b exp=%b", $time, DW_RDY, exp_rdy);
    end
    hg       = !DW_RDY;
    rd_acc   = DW_OE && !DW_WE && DW_RDY;
    accepted = (DW_OE || DW_WE) && DW_RDY;
    hg_rd    = hg && !H_WE;
    if (rd_acc) q_dwi.push_back(mread(DW_A));
    if (hg_rd) q_hrd.push_back(mread(H_A));
    if (DW_WE && DW_RDY) mwrite(DW_A, DW_O);
    if (hg && H_WE) mwrite(H_A, H_WD);
    @(posedge CLK);
    cmp    = pend_r;
    pend_r = rd_acc;
    @(negedge CLK);
    checks++;
    if (H_ACK !== exp_ack) begin
      failures++;
      $display("FAIL h_ack t=%0t got=%b exp=%b", $time, H_ACK, exp_ack);
    end
    if (cmp) begin
      if (q_dwi.size() == 0) begin
        checks++; failures++;
        $display("FAIL dw_i_queue_empty t=%0t", $time);
      end else begin
        last_dwi = q_dwi.pop_front();
      end
    end
    checks++;
    if (DW_I !== last_dwi) begin
      failures++;
      $display("FAIL dw_i t=%0t got=%h exp=%h", $time, DW_I, last_dwi);
    end
    if (hg_rd) begin
      if (q_hrd.size() == 0) begin
        checks++; failures++;
        $display("FAIL h_rd_queue_empty t=%0t", $time);
      end else begin
        last_hrd = q_hrd.pop_front();
      end
    end
    checks++;
    if (H_RD !== last_hrd) begin
      failures++;
      $display("FAIL h_rd t=%0t got=%h exp=%h", $time, H_RD, last_hrd);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    CLR = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    checks++;
    if (DW_I !== 32'h0 || H_ACK !== 1'b0 || H_RD !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs dw_i=%h h_ack=%b h_rd=%h exp=0/0/0", DW_I, H_ACK, H_RD);
    end
    CLR = 1'b0;
    clear_sb();
    tick(1'b1, 1'b0, acc);
  endtask

  task automatic test_store_load();
    DW_WE = 1'b1; DW_A = 16'h0010; DW_O = 32'hDEADBEEF;
    tick(1'b1, 1'b0, acc);
    DW_WE = 1'b0; DW_OE = 1'b1;
    tick(1'b1, 1'b0, acc);
    DW_OE = 1'b0;
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, acc);
    // preload words used by later scenarios
    DW_WE = 1'b1;
    DW_A = 16'h0020; DW_O = 32'h12345678; tick(1'b1, 1'b0, acc);
    DW_A = 16'h0000; DW_O = 32'hA5A50000; tick(1'b1, 1'b0, acc);
    for (int i = 0; i < 12; i++) begin
      DW_A = 16'h0100 + 16'(i);
      DW_O = 32'hC0DE0000 + 32'(i);
      tick(1'b1, 1'b0, acc);
    end
    DW_WE = 1'b0;
  endtask

  task automatic test_host_access();
    H_REQ = 1'b1; H_WE = 1'b0; H_A = 16'h0020;
    tick(1'b0, 1'b1, acc);
    tick(1'b1, 1'b0, acc);
    H_REQ = 1'b0;
    tick(1'b1, 1'b0, acc);
    H_REQ = 1'b1; H_WE = 1'b1; H_A = 16'h0030; H_WD = 32'h0BADF00D;
    tick(1'b0, 1'b1, acc);
    H_REQ = 1'b0;
    tick(1'b1, 1'b0, acc);
    DW_OE = 1'b1; DW_A = 16'h0030;
    tick(1'b1, 1'b0, acc);
    DW_OE = 1'b0;
    tick(1'b1, 1'b0, acc);
    tick(1'b1, 1'b0, acc);
  endtask

  task automatic starve_run(input logic [15:0] start);
    DW_OE = 1'b1; DW_A = start;
    H_REQ = 1'b1; H_WE = 1'b0; H_A = 16'h0010;
    for (int i = 1; i <= 6; i++) begin
      tick(logic'(i != 5), logic'(i == 5), acc);
      if (acc) DW_A = DW_A + 1'b1;
      if (i == 6) H_REQ = 1'b0;
    end
    tick(1'b1, 1'b0, acc);
    DW_OE = 1'b0;
    tick(1'b1, 1'b0, acc);
    tick(1'b1, 1'b0, acc);
    checks++;
    if (q_dwi.size() != 0 || q_hrd.size() != 0) begin
      failures++;
      $display("FAIL starve_drain dwi_left=%0d hrd_left=%0d exp=0/0", q_dwi.size(), q_hrd.size());
    end
  endtask

  task automatic test_starvation();
    starve_run(16'h0100);
  endtask

  task automatic test_out_of_range();
    DW_WE = 1'b1; DW_A = 16'h0400; DW_O = 32'h0000FFFF;
    tick(1'b1, 1'b0, acc);
    DW_WE = 1'b0; DW_OE = 1'b1;
    tick(1'b1, 1'b0, acc);
    DW_A = 16'h0000;
    tick(1'b1, 1'b0, acc);
    DW_A = 16'h0400;
    tick(1'b1, 1'b0, acc);
    DW_OE = 1'b0;
    H_REQ = 1'b1; H_WE = 1'b0; H_A = 16'h0400;
    tick(1'b0, 1'b1, acc);
    H_REQ = 1'b0;
    tick(1'b1, 1'b0, acc);
  endtask

  task automatic test_reset_mid_host();
    DW_OE = 1'b1; DW_A = 16'h0100;
    H_REQ = 1'b1; H_WE = 1'b0; H_A = 16'h0020;
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, acc);
    DW_OE = 1'b0;
    #1;
    checks++;
    if (DW_RDY !== 1'b0) begin
      failures++;
      $display("FAIL mid_grant got=%b exp=0", DW_RDY);
    end
    @(posedge CLK);
    #1 CLR = 1'b1;
    #1;
    checks++;
    if (H_ACK !== 1'b0 || DW_I !== 32'h0 || H_RD !== 32'h0) begin
      failures++;
      $display("FAIL mid_reset h_ack=%b dw_i=%h h_rd=%h exp=0/0/0", H_ACK, DW_I, H_RD);
    end
    @(negedge CLK);
    CLR = 1'b0;
    clear_sb();
    starve_run(16'h0104);
    H_REQ = 1'b1; H_WE = 1'b0; H_A = 16'h0020;
    tick(1'b0, 1'b1, acc);
    H_REQ = 1'b0;
    tick(1'b1, 1'b0, acc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    CLR = 1'b1;
    clear_sb();
    @(negedge CLK);
    test_reset();
    test_store_load();
    test_host_access();
    test_starvation();
    test_out_of_range();
    test_reset_mid_host();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
